matmul_result_checker: RTL and testbench

Synthesizable, parametrised result checker for the matmul accelerator. Walks a runtime-sized rows x cols window of the flattened scratchpad result and compares each element, in row-major order, against an expected-value stream. Reports per-run error count, pass/fail and a one-cycle completion pulse. Sits beside the scratchpad in the verification and self-test path.

---
 rtl/matmul_result_checker.sv | 188 ++++++++++++++++++
 tb/tb_matmul_result_checker.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/matmul_result_checker.sv
// matmul_result_checker: walks a rows x cols window of the flattened
// scratchpad in row-major order and compares each element, extended to
// EXP_W, against an expected-value stream. Reports a saturating error
// count, pass/fail and a one-cycle done pulse.
//
// Optional build macro: MATMUL_CHK_FIRST_ERR_EN adds first-mismatch capture
// outputs (position, extended element, expected value).
//
// state | meaning
// IDLE  | waiting for start_i; results of last run held
// RUN   | accepting expected values, one element per beat
// DONE  | one-cycle completion, done_o asserted
module matmul_result_checker #(
   parameter int BUS_WIDTH = 16,
   parameter int MAX_DIM   = 4,
   parameter int EXP_W     = 2*BUS_WIDTH,
   parameter int ERR_CNT_W = 8,
   localparam int DIM_W    = $clog2(MAX_DIM+1),
   localparam int IDX_W    = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 start_i,
   input  logic [DIM_W-1:0]                     rows_i,
   input  logic [DIM_W-1:0]                     cols_i,
   input  logic                                 signed_i,
   input  logic [BUS_WIDTH*MAX_DIM*MAX_DIM-1:0] data_sp_i,
   input  logic                                 exp_valid_i,
   input  logic [EXP_W-1:0]                     exp_data_i,
   output logic                                 exp_ready_o,
   output logic                                 busy_o,
   output logic                                 done_o,
   output logic                                 pass_o,
`ifdef MATMUL_CHK_FIRST_ERR_EN
   output logic                                 first_err_valid_o,
   output logic [IDX_W-1:0]                     first_err_row_o,
   output logic [IDX_W-1:0]                     first_err_col_o,
   output logic [EXP_W-1:0]                     first_err_got_o,
   output logic [EXP_W-1:0]                     first_err_exp_o,
`endif
   output logic [ERR_CNT_W-1:0]                 err_cnt_o
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;
   logic [DIM_W-1:0]      rows_q, cols_q;
   logic                  signed_q;
   logic [IDX_W-1:0]      row_q, col_q;
   logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
   logic                  pass_q;

   logic [BUS_WIDTH-1:0]  elem [MAX_DIM][MAX_DIM];
   logic [BUS_WIDTH-1:0]  elem_sel;
   logic [EXP_W-1:0]      elem_ext;
   logic                  start_acc, zero_run, beat, mismatch;
   logic                  col_last, row_last, last_beat;

   function automatic logic [DIM_W-1:0] clamp_dim(input logic [DIM_W-1:0] v);
      return (v > DIM_W'(MAX_DIM)) ? DIM_W'(MAX_DIM) : v;
   endfunction

   for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
      for (genvar c = 0; c < MAX_DIM; c++) begin : g_col
         assign elem[r][c] = data_sp_i[(r*MAX_DIM+c)*BUS_WIDTH +: BUS_WIDTH];
      end
   end

   assign elem_sel  = elem[row_q][col_q];
   assign start_acc = (state_q == IDLE) && start_i;
   assign zero_run  = (rows_i == '0) || (cols_i == '0);
   assign beat      = (state_q == RUN) && exp_valid_i;
   assign mismatch  = (elem_ext != exp_data_i);
   assign col_last  = (DIM_W'(col_q) == cols_q - DIM_W'(1));
   assign row_last  = (DIM_W'(row_q) == rows_q - DIM_W'(1));
   assign last_beat = beat && col_last && row_last;

   // Extend the selected element to the expected-value width.
   always_comb begin
      elem_ext = '0;
      elem_ext[BUS_WIDTH-1:0] = elem_sel;
      if (signed_q) begin
         for (int i = BUS_WIDTH; i < EXP_W; i++) begin
            elem_ext[i] = elem_sel[BUS_WIDTH-1];
         end
      end
   end

   // Next error count: cleared on start, saturating increment on mismatch.
   always_comb begin
      err_cnt_d = err_cnt_q;
      if (start_acc) begin
         err_cnt_d = '0;
      end else if (beat && mismatch && (err_cnt_q != '1)) begin
         err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      end
   end

   // State register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state and handshake/status outputs.
   always_comb begin
      state_d     = state_q;
      exp_ready_o = 1'b0;
      busy_o      = 1'b0;
      done_o      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start_i) state_d = zero_run ? DONE : RUN;
         end
         RUN: begin
            busy_o      = 1'b1;
            exp_ready_o = 1'b1;
            if (last_beat) state_d = DONE;
         end
         DONE: begin
            done_o  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Run configuration, walk indices, error count and verdict.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rows_q    <= '0;
         cols_q    <= '0;
         signed_q  <= 1'b0;
         row_q     <= '0;
         col_q     <= '0;
         err_cnt_q <= '0;
         pass_q    <= 1'b0;
      end else begin
         err_cnt_q <= err_cnt_d;
         if (start_acc) begin
            rows_q   <= clamp_dim(rows_i);
            cols_q   <= clamp_dim(cols_i);
            signed_q <= signed_i;
            row_q    <= '0;
            col_q    <= '0;
            // A zero-size run has no beats, so its verdict is known now.
            pass_q   <= zero_run;
         end else if (beat) begin
            if (col_last) begin
               col_q <= '0;
               row_q <= row_q + IDX_W'(1);
            end else begin
               col_q <= col_q + IDX_W'(1);
            end
            if (last_beat) pass_q <= (err_cnt_d == '0);
         end
      end
   end

`ifdef MATMUL_CHK_FIRST_ERR_EN
   // Capture the position and values of the first mismatch of a run.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         first_err_valid_o <= 1'b0;
         first_err_row_o   <= '0;
         first_err_col_o   <= '0;
         first_err_got_o   <= '0;
         first_err_exp_o   <= '0;
      end else if (start_acc) begin
         first_err_valid_o <= 1'b0;
         first_err_row_o   <= '0;
         first_err_col_o   <= '0;
         first_err_got_o   <= '0;
         first_err_exp_o   <= '0;
      end else if (beat && mismatch && !first_err_valid_o) begin
         first_err_valid_o <= 1'b1;
         first_err_row_o   <= row_q;
         first_err_col_o   <= col_q;
         first_err_got_o   <= elem_ext;
         first_err_exp_o   <= exp_data_i;
      end
   end
`endif

   assign pass_o    = pass_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_matmul_result_checker.sv
// Bench for matmul_result_checker: table of check runs with a scoreboard of
// expected verdicts, plus a hand-written mid-run reset sequence.
module tb_matmul_result_checker;

   localparam int BW = 16;
   localparam int MD = 4;
   localparam int EW = 32;
   localparam int CW = 8;

   logic               clk_i = 1'b0;
   logic               rst_i = 1'b1;
   logic               start_i = 1'b0;
   logic [2:0]         rows_i = '0;
   logic [2:0]         cols_i = '0;
   logic               signed_i = 1'b0;
   logic [BW*MD*MD-1:0] data_sp_i = '0;
   logic               exp_valid_i = 1'b0;
   logic [EW-1:0]      exp_data_i = '0;
   logic               exp_ready_o, busy_o, done_o, pass_o;
   logic [CW-1:0]      err_cnt_o;
`ifdef MATMUL_CHK_FIRST_ERR_EN
   logic               first_err_valid_o;
   logic [1:0]         first_err_row_o, first_err_col_o;
   logic [EW-1:0]      first_err_got_o, first_err_exp_o;
`endif

   matmul_result_checker #(.BUS_WIDTH(BW), .MAX_DIM(MD), .EXP_W(EW), .ERR_CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .rows_i(rows_i), .cols_i(cols_i),
      .signed_i(signed_i), .data_sp_i(data_sp_i), .exp_valid_i(exp_valid_i),
      .exp_data_i(exp_data_i), .exp_ready_o(exp_ready_o), .busy_o(busy_o),
      .done_o(done_o), .pass_o(pass_o),
`ifdef MATMUL_CHK_FIRST_ERR_EN
      .first_err_valid_o(first_err_valid_o), .first_err_row_o(first_err_row_o),
      .first_err_col_o(first_err_col_o), .first_err_got_o(first_err_got_o),
      .first_err_exp_o(first_err_exp_o),
`endif
      .err_cnt_o(err_cnt_o));

   always #5 clk_i = ~clk_i;

   typedef struct {
      int          rows;
      int          cols;
      bit          sgn;
      logic [15:0] base;
      int          bad_r;
      int          bad_c;
      logic [31:0] bad_val;
      bit          gap;
      bit          mid_start;
      int          exp_err;
      bit          exp_pass;
   } vec_t;

   typedef struct {
      int err;
      bit pass;
   } verdict_t;

   vec_t     vecs[8];
   verdict_t sb[$];
   int       n_tests = 0;
   int       n_fail = 0;
   int       beat_cnt = 0;
   int       done_cnt = 0;
   int       ready_cnt = 0;

   always @(posedge clk_i) begin
      if (exp_valid_i && exp_ready_o) beat_cnt++;
      if (done_o) done_cnt++;
      if (exp_ready_o) ready_cnt++;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [31:0] model_ext(input logic [15:0] e, input bit s);
      return s ? {{16{e[15]}}, e} : {16'h0000, e};
   endfunction

   function automatic logic [15:0] sp_elem(input logic [15:0] base, input int r, input int c);
      return base + 16'(r*MD + c);
   endfunction

   task automatic run_vec(input vec_t v, input int idx);
      int er, ec, n, b0, d0, r0;
      verdict_t vd;
      er = (v.rows > MD) ? MD : v.rows;
      ec = (v.cols > MD) ? MD : v.cols;
      n  = er * ec;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            data_sp_i[(r*MD+c)*BW +: BW] = sp_elem(v.base, r, c);
      b0 = beat_cnt; d0 = done_cnt; r0 = ready_cnt;
      @(negedge clk_i);
      start_i  = 1'b1;
      rows_i   = 3'(v.rows);
      cols_i   = 3'(v.cols);
      signed_i = v.sgn;
      sb.push_back('{v.exp_err, v.exp_pass});
      @(negedge clk_i);
      start_i = 1'b0;
      if (n > 0) begin
         check($sformatf("v%0d busy_after_start", idx), 64'(busy_o), 64'd1);
         check($sformatf("v%0d ready_after_start", idx), 64'(exp_ready_o), 64'd1);
         for (int r = 0; r < er; r++) begin
            for (int c = 0; c < ec; c++) begin
               if (v.gap) begin
                  exp_valid_i = 1'b0;
                  if (v.mid_start && (r*ec + c) == 3) begin
                     start_i = 1'b1; rows_i = 3'd1; cols_i = 3'd1;
                  end
                  @(negedge clk_i);
                  start_i = 1'b0;
               end
               exp_valid_i = 1'b1;
               exp_data_i  = (r == v.bad_r && c == v.bad_c) ? v.bad_val
                                                           : model_ext(sp_elem(v.base, r, c), v.sgn);
               @(negedge clk_i);
            end
         end
         exp_valid_i = 1'b0;
      end
      check($sformatf("v%0d done_pulse", idx), 64'(done_o), 64'd1);
      check($sformatf("v%0d ready_low_at_done", idx), 64'(exp_ready_o), 64'd0);
      check($sformatf("v%0d busy_low_at_done", idx), 64'(busy_o), 64'd0);
      if (sb.size() == 0) begin
         check($sformatf("v%0d scoreboard_nonempty", idx), 64'd0, 64'd1);
      end else begin
         vd = sb.pop_front();
         check($sformatf("v%0d err_cnt", idx), 64'(err_cnt_o), 64'(vd.err));
         check($sformatf("v%0d pass", idx), 64'(pass_o), 64'(vd.pass));
      end
      check($sformatf("v%0d beats", idx), 64'(beat_cnt - b0), 64'(n));
      if (n == 0) check($sformatf("v%0d ready_never_high", idx), 64'(ready_cnt - r0), 64'd0);
`ifdef MATMUL_CHK_FIRST_ERR_EN
      if (v.exp_err > 0) begin
         check($sformatf("v%0d first_valid", idx), 64'(first_err_valid_o), 64'd1);
         check($sformatf("v%0d first_row", idx), 64'(first_err_row_o), 64'(v.bad_r));
         check($sformatf("v%0d first_col", idx), 64'(first_err_col_o), 64'(v.bad_c));
         check($sformatf("v%0d first_got", idx), 64'(first_err_got_o),
               64'(model_ext(sp_elem(v.base, v.bad_r, v.bad_c), v.sgn)));
         check($sformatf("v%0d first_exp", idx), 64'(first_err_exp_o), 64'(v.bad_val));
      end else begin
         check($sformatf("v%0d first_valid_clear", idx), 64'(first_err_valid_o), 64'd0);
      end
`endif
      @(negedge clk_i);
      check($sformatf("v%0d done_one_cycle", idx), 64'(done_o), 64'd0);
      check($sformatf("v%0d done_count", idx), 64'(done_cnt - d0), 64'd1);
      check($sformatf("v%0d pass_held", idx), 64'(pass_o), 64'(v.exp_pass));
   endtask

   initial begin
      //            rows cols sgn base      bad_r bad_c bad_val        gap mid err pass
      vecs[0] = '{2, 2, 1'b1, 16'h0001, -1, -1, 32'h0,        1'b0, 1'b0, 0, 1'b1};
      vecs[1] = '{3, 3, 1'b1, 16'h0001,  1,  2, 32'd99,       1'b0, 1'b0, 1, 1'b0};
      vecs[2] = '{1, 1, 1'b1, 16'hFFFF,  0,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 0, 1'b1};
      vecs[3] = '{1, 1, 1'b0, 16'hFFFF,  0,  0, 32'hFFFFFFFF, 1'b0, 1'b0, 1, 1'b0};
      vecs[4] = '{4, 4, 1'b1, 16'h8000, -1, -1, 32'h0,        1'b1, 1'b1, 0, 1'b1};
      vecs[5] = '{0, 3, 1'b0, 16'h0010, -1, -1, 32'h0,        1'b0, 1'b0, 0, 1'b1};
      vecs[6] = '{7, 2, 1'b0, 16'h0010, -1, -1, 32'h0,        1'b0, 1'b0, 0, 1'b1};
      vecs[7] = '{2, 3, 1'b0, 16'h8000,  1,  1, 32'h0,        1'b0, 1'b0, 1, 1'b0};

      #12;
      check("reset busy", 64'(busy_o), 64'd0);
      check("reset ready", 64'(exp_ready_o), 64'd0);
      check("reset done", 64'(done_o), 64'd0);
      check("reset pass", 64'(pass_o), 64'd0);
      check("reset err_cnt", 64'(err_cnt_o), 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

      // Mid-run reset: 5 mismatching beats of a 4x4 run, then reset.
      begin
         int d0;
         for (int r = 0; r < MD; r++)
            for (int c = 0; c < MD; c++)
               data_sp_i[(r*MD+c)*BW +: BW] = sp_elem(16'h0001, r, c);
         d0 = done_cnt;
         @(negedge clk_i);
         start_i = 1'b1; rows_i = 3'd4; cols_i = 3'd4; signed_i = 1'b1;
         @(negedge clk_i);
         start_i = 1'b0;
         for (int k = 0; k < 5; k++) begin
            exp_valid_i = 1'b1;
            exp_data_i  = 32'h0;
            @(negedge clk_i);
         end
         check("rst_seq live err_cnt", 64'(err_cnt_o), 64'd5);
         check("rst_seq busy before rst", 64'(busy_o), 64'd1);
         rst_i = 1'b1;
         #1;
         check("rst_seq busy", 64'(busy_o), 64'd0);
         check("rst_seq ready", 64'(exp_ready_o), 64'd0);
         check("rst_seq err_cnt", 64'(err_cnt_o), 64'd0);
         check("rst_seq pass", 64'(pass_o), 64'd0);
         exp_valid_i = 1'b0;
         @(negedge clk_i);
         @(negedge clk_i);
         rst_i = 1'b0;
         @(negedge clk_i);
         check("rst_seq no done", 64'(done_cnt - d0), 64'd0);
         check("rst_seq sb empty", 64'(sb.size()), 64'd0);
      end
      run_vec(vecs[0], 8);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
